// File: rtl/pulse_seq_pkg.sv
// Shared opcodes, FSM states and status bit positions for pulse_sequencer.
// Optional trigger synchronizer is enabled with PULSE_SEQ_TRIG_SYNC_EN.
package pulse_seq_pkg;

  typedef enum logic [3:0] {
    OP_CONT       = 4'd0,
    OP_STOP       = 4'd1,
    OP_LOOP_START = 4'd2,
    OP_LOOP_END   = 4'd3,
    OP_WAIT_TRIG  = 4'd4,
    OP_JUMP       = 4'd5
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_HOLD,
    S_WAIT_TRIG,
    S_DONE,
    S_ERROR
  } state_e;

  localparam int ST_IDLE    = 0;
  localparam int ST_RUNNING = 1;
  localparam int ST_DONE    = 2;
  localparam int ST_WAIT    = 3;
  localparam int ST_ERROR   = 4;

endpackage

// File: rtl/pulse_sequencer_loop_stack.sv
// LIFO of {return address, remaining count} for nested counted loops.
// Caller guarantees push only when !full and pop/dec only when !empty.
module loop_stack
  import pulse_seq_pkg::*;
#(
  parameter int AW    = 16,
  parameter int CW    = 20,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic          dec,
  input  logic [AW-1:0] push_addr,
  input  logic [CW-1:0] push_cnt,
  output logic [AW-1:0] top_addr,
  output logic [CW-1:0] top_cnt,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [AW-1:0] addr_mem [DEPTH];
  logic [CW-1:0] cnt_mem  [DEPTH];

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  always_comb begin
    top_addr = '0;
    top_cnt  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (LW'(i + 1) == level) begin
        top_addr = addr_mem[i];
        top_cnt  = cnt_mem[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      level <= '0;
    end else if (push && !full) begin
      level <= level + LW'(1);
    end else if (pop && !empty) begin
      level <= level - LW'(1);
    end
  end

  // Entry storage needs no reset: only entries below level are read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!reset && !clear) begin
        if (push && !full && LW'(i) == level) begin
          addr_mem[i] <= push_addr;
          cnt_mem[i]  <= push_cnt;
        end else if (dec && !empty &&
                     LW'(i + 1) == level) begin
          cnt_mem[i] <= cnt_mem[i] - CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pulse_sequencer.sv
// Instruction-driven pulse sequencer with nested loops and trigger waits.
// Define PULSE_SEQ_TRIG_SYNC_EN to add a 2-flop trigger synchronizer.
module pulse_sequencer
  import pulse_seq_pkg::*;
#(
  parameter int NUM_CHANNELS = 64,
  parameter int ADDR_SIZE    = 16,
  parameter int DATA_WIDTH   = 20,
  parameter int TIME_WIDTH   = 32,
  parameter int LOOP_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic                    trigger,
  input  logic [NUM_CHANNELS-1:0] flg,
  input  logic [3:0]              op_code,
  input  logic [DATA_WIDTH-1:0]   data,
  input  logic [TIME_WIDTH-1:0]   time_arg,
  output logic [NUM_CHANNELS-1:0] channels,
  output logic [4:0]              status,
  output logic [ADDR_SIZE-1:0]    mem_addr,
  output logic [$clog2(LOOP_DEPTH+1)-1:0] loop_level
);

  state_e                  state, state_d;
  logic [ADDR_SIZE-1:0]    pc, pc_d, pc_inc;
  logic [ADDR_SIZE-1:0]    mem_addr_d;
  logic [NUM_CHANNELS-1:0] chan_d;
  logic [TIME_WIDTH-1:0]   hold_cnt, cnt_d;
  logic                    push, pop, dec, clear;
  logic [ADDR_SIZE-1:0]    top_addr;
  logic [DATA_WIDTH-1:0]   top_cnt;
  logic                    full, empty;
  logic                    trig_s, trig_q, trig_edge;

`ifdef PULSE_SEQ_TRIG_SYNC_EN
  logic [1:0] trig_sync;
  always_ff @(posedge clk) begin
    if (reset) trig_sync <= '0;
    else       trig_sync <= {trig_sync[0], trigger};
  end
  assign trig_s = trig_sync[1];
`else
  assign trig_s = trigger;
`endif

  assign trig_edge = trig_s & ~trig_q;
  assign pc_inc    = pc + ADDR_SIZE'(1);

  loop_stack #(
    .AW    (ADDR_SIZE),
    .CW    (DATA_WIDTH),
    .DEPTH (LOOP_DEPTH)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .push      (push),
    .pop       (pop),
    .dec       (dec),
    .push_addr (pc_inc),
    .push_cnt  (data),
    .top_addr  (top_addr),
    .top_cnt   (top_cnt),
    .full      (full),
    .empty     (empty),
    .level     (loop_level)
  );

  always_comb begin
    state_d = state;
    pc_d    = pc;
    chan_d  = channels;
    cnt_d   = hold_cnt;
    push    = 1'b0;
    pop     = 1'b0;
    dec     = 1'b0;
    clear   = 1'b0;
    unique case (state)
      S_IDLE: begin
        pc_d = '0;
        if (run) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        cnt_d = time_arg;
        unique case (1'b1)
          (op_code == OP_CONT): begin
            chan_d  = flg;
            pc_d    = pc_inc;
            state_d = (time_arg == '0) ? S_FETCH : S_HOLD;
          end
          (op_code == OP_STOP): state_d = S_DONE;
          (op_code == OP_LOOP_START): begin
            if (full) begin
              state_d = S_ERROR;
            end else begin
              push    = 1'b1;
              chan_d  = flg;
              pc_d    = pc_inc;
              state_d = (time_arg == '0) ? S_FETCH : S_HOLD;
            end
          end
          (op_code == OP_LOOP_END): begin
            if (empty) begin
              state_d = S_ERROR;
            end else begin
              chan_d  = flg;
              state_d = (time_arg == '0) ? S_FETCH : S_HOLD;
              if (top_cnt == '0) begin
                pop  = 1'b1;
                pc_d = pc_inc;
              end else begin
                dec  = 1'b1;
                pc_d = top_addr;
              end
            end
          end
          (op_code == OP_WAIT_TRIG): begin
            chan_d  = flg;
            pc_d    = pc_inc;
            state_d = S_WAIT_TRIG;
          end
          (op_code == OP_JUMP): begin
            pc_d    = data[ADDR_SIZE-1:0];
            state_d = (time_arg == '0) ? S_FETCH : S_HOLD;
          end
          default: state_d = S_ERROR;
        endcase
      end
      S_HOLD: begin
        if (hold_cnt <= TIME_WIDTH'(1)) state_d = S_FETCH;
        else cnt_d = hold_cnt - TIME_WIDTH'(1);
      end
      S_WAIT_TRIG: begin
        if (trig_edge)
          state_d = (hold_cnt == '0) ? S_FETCH : S_HOLD;
      end
      S_DONE:  state_d = S_DONE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
    // Abort wins over anything decoded this cycle.
    if (!run && state != S_IDLE) begin
      state_d = S_IDLE;
      pc_d    = '0;
      chan_d  = channels;
      push    = 1'b0;
      pop     = 1'b0;
      dec     = 1'b0;
      clear   = 1'b1;
    end
  end

  always_comb begin
    mem_addr_d = mem_addr;
    if (state_d == S_FETCH)     mem_addr_d = pc_d;
    else if (state_d == S_IDLE) mem_addr_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      pc       <= '0;
      mem_addr <= '0;
      channels <= '0;
      hold_cnt <= '0;
      trig_q   <= 1'b0;
    end else begin
      state    <= state_d;
      pc       <= pc_d;
      mem_addr <= mem_addr_d;
      channels <= chan_d;
      hold_cnt <= cnt_d;
      trig_q   <= trig_s;
    end
  end

  always_comb begin
    status = '0;
    unique case (state)
      S_IDLE:      status[ST_IDLE]    = 1'b1;
      S_FETCH,
      S_DECODE,
      S_HOLD:      status[ST_RUNNING] = 1'b1;
      S_WAIT_TRIG: status[ST_WAIT]    = 1'b1;
      S_DONE:      status[ST_DONE]    = 1'b1;
      S_ERROR:     status[ST_ERROR]   = 1'b1;
      default:     status             = '0;
    endcase
  end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Self-checking bench for pulse_sequencer: directed scenarios plus
// random programs checked against a cycle-level program interpreter.
module tb_pulse_sequencer;

  localparam logic [4:0] ST_IDL = 5'b00001;
  localparam logic [4:0] ST_RUN = 5'b00010;
  localparam logic [4:0] ST_DON = 5'b00100;
  localparam logic [4:0] ST_WAI = 5'b01000;
  localparam logic [4:0] ST_ERR = 5'b10000;
`ifdef PULSE_SEQ_TRIG_SYNC_EN
  localparam int TRIG_LAT = 7;
`else
  localparam int TRIG_LAT = 5;
`endif
  localparam int NCYC = 120;

  typedef struct packed {
    logic [3:0]  op;
    logic [63:0] flg;
    logic [19:0] data;
    logic [31:0] t;
  } ins_t;

  typedef struct packed {
    logic [63:0] ch;
    logic [15:0] addr;
    logic [4:0]  st;
    logic [2:0]  lvl;
  } exp_t;

  logic        clk_tb = 1'b0;
  logic        reset, run, trigger;
  logic [63:0] flg;
  logic [3:0]  op_code;
  logic [19:0] data;
  logic [31:0] time_arg;
  logic [63:0] channels;
  logic [4:0]  status;
  logic [15:0] mem_addr;
  logic [2:0]  loop_level;

  int n_cmp = 0;
  int n_err = 0;
  ins_t prog [16];

  pulse_sequencer dut (
    .clk        (clk_tb),
    .reset      (reset),
    .run        (run),
    .trigger    (trigger),
    .flg        (flg),
    .op_code    (op_code),
    .data       (data),
    .time_arg   (time_arg),
    .channels   (channels),
    .status     (status),
    .mem_addr   (mem_addr),
    .loop_level (loop_level)
  );

  initial forever #5 clk_tb = ~clk_tb;

  // Synchronous instruction memory, one cycle read latency.
  always @(posedge clk_tb) begin
    op_code  <= prog[mem_addr[3:0]].op;
    flg      <= prog[mem_addr[3:0]].flg;
    data     <= prog[mem_addr[3:0]].data;
    time_arg <= prog[mem_addr[3:0]].t;
  end

  function automatic ins_t mk(input logic [3:0] op,
                              input logic [63:0] f,
                              input logic [19:0] d,
                              input logic [31:0] t);
    ins_t r;
    r.op = op; r.flg = f; r.data = d; r.t = t;
    return r;
  endfunction

  function automatic exp_t ex(input logic [63:0] ch,
                              input logic [15:0] a,
                              input logic [4:0] st,
                              input int lvl);
    exp_t e;
    e.ch = ch; e.addr = a; e.st = st; e.lvl = 3'(lvl);
    return e;
  endfunction

  function automatic ins_t rand_ins();
    ins_t r;
    int k;
    k = $urandom_range(0, 99);
    r.flg  = {$urandom, $urandom};
    r.t    = 32'($urandom_range(0, 3));
    r.data = 20'($urandom_range(0, 3));
    if (k < 40)      r.op = 4'd0;
    else if (k < 55) r.op = 4'd2;
    else if (k < 72) r.op = 4'd3;
    else if (k < 82) begin
      r.op = 4'd5;
      if ($urandom_range(0, 4) == 0) r.data = 20'hAFFFF;
      else r.data = 20'($urandom_range(0, 15));
    end
    else if (k < 92) r.op = 4'd1;
    else r.op = 4'($urandom_range(6, 15));
    return r;
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = mk(4'd1, '0, '0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run   = 1'b0;
    repeat (2) @(negedge clk_tb);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    @(negedge clk_tb);
    n_cmp++;
    if (channels !== 64'd0) begin
      n_err++;
      $display("FAIL reset_channels got %h want 0", channels);
    end
    n_cmp++;
    if (mem_addr !== 16'd0) begin
      n_err++;
      $display("FAIL reset_mem_addr got %h want 0", mem_addr);
    end
    n_cmp++;
    if (status !== ST_IDL) begin
      n_err++;
      $display("FAIL reset_status got %b want %b", status, ST_IDL);
    end
    n_cmp++;
    if (loop_level !== 3'd0) begin
      n_err++;
      $display("FAIL reset_level got %0d want 0", loop_level);
    end
    reset = 1'b0;
    @(negedge clk_tb);
  endtask

  task automatic test_cont_stop();
    clear_prog();
    prog[0] = mk(4'd0, 64'd1, '0, 32'd3);
    prog[1] = mk(4'd1, 64'hF0, '0, '0);
    run = 1'b1;
    for (int s = 0; s < 8; s++) begin
      @(negedge clk_tb);
      if (s == 1) begin
        n_cmp++;
        if (channels !== 64'd0) begin
          n_err++;
          $display("FAIL cs_early_ch got %h want 0", channels);
        end
      end
      if (s == 2) begin
        n_cmp++;
        if (channels !== 64'd1) begin
          n_err++;
          $display("FAIL cs_ch got %h want 1", channels);
        end
      end
      if (s == 4) begin
        n_cmp++;
        if (mem_addr !== 16'd0 || status !== ST_RUN) begin
          n_err++;
          $display("FAIL cs_hold got a=%h st=%b want a=0 st=%b",
                   mem_addr, status, ST_RUN);
        end
      end
      if (s == 5) begin
        n_cmp++;
        if (mem_addr !== 16'd1) begin
          n_err++;
          $display("FAIL cs_fetch2 got %h want 1", mem_addr);
        end
      end
    end
    n_cmp++;
    if (status !== ST_DON || channels !== 64'd1) begin
      n_err++;
      $display("FAIL cs_done got st=%b ch=%h want st=%b ch=1",
               status, channels, ST_DON);
    end
    run = 1'b0;
    @(negedge clk_tb);
  endtask

  task automatic test_loop();
    int body, bad, done;
    clear_prog();
    prog[0] = mk(4'd2, 64'hA, 20'd2, '0);
    prog[1] = mk(4'd0, 64'h1, '0, '0);
    prog[2] = mk(4'd3, 64'h2, '0, '0);
    body = 0; bad = 0; done = 0;
    run = 1'b1;
    for (int c = 0; c < 100 && done == 0; c++) begin
      @(negedge clk_tb);
      if (status === ST_RUN && mem_addr === 16'd1) begin
        body++;
        if (loop_level !== 3'd1) bad++;
      end
      if (status !== ST_RUN) done = 1;
    end
    n_cmp++;
    if (status !== ST_DON) begin
      n_err++;
      $display("FAIL loop_done got %b want %b", status, ST_DON);
    end
    n_cmp++;
    if (body != 6) begin
      n_err++;
      $display("FAIL loop_body got %0d cycles want 6", body);
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL loop_level_in got %0d bad want 0", bad);
    end
    n_cmp++;
    if (loop_level !== 3'd0) begin
      n_err++;
      $display("FAIL loop_level_after got %0d want 0", loop_level);
    end
    run = 1'b0;
    @(negedge clk_tb);
  endtask

  task automatic test_overflow();
    int done;
    clear_prog();
    for (int i = 0; i < 5; i++)
      prog[i] = mk(4'd2, 64'(i + 1), '0, '0);
    done = 0;
    run = 1'b1;
    for (int c = 0; c < 50 && done == 0; c++) begin
      @(negedge clk_tb);
      if (status !== ST_RUN) done = 1;
    end
    n_cmp++;
    if (status !== ST_ERR || mem_addr !== 16'd4) begin
      n_err++;
      $display("FAIL ovf_err got st=%b a=%h want st=%b a=4",
               status, mem_addr, ST_ERR);
    end
    n_cmp++;
    if (loop_level !== 3'd4) begin
      n_err++;
      $display("FAIL ovf_level got %0d want 4", loop_level);
    end
    run = 1'b0;
    @(negedge clk_tb);
    n_cmp++;
    if (status !== ST_IDL || loop_level !== 3'd0) begin
      n_err++;
      $display("FAIL ovf_abort got st=%b l=%0d want st=%b l=0",
               status, loop_level, ST_IDL);
    end
  endtask

  task automatic test_wait_trig();
    clear_prog();
    prog[0] = mk(4'd4, 64'd5, '0, 32'd4);
    prog[1] = mk(4'd0, 64'd7, '0, '0);
    trigger = 1'b1;
    run = 1'b1;
    repeat (3) @(negedge clk_tb);
    n_cmp++;
    if (channels !== 64'd5 || status !== ST_WAI) begin
      n_err++;
      $display("FAIL wt_enter got ch=%h st=%b want ch=5 st=%b",
               channels, status, ST_WAI);
    end
    repeat (18) @(negedge clk_tb);
    n_cmp++;
    if (status !== ST_WAI) begin
      n_err++;
      $display("FAIL wt_held got %b want %b", status, ST_WAI);
    end
    trigger = 1'b0;
    repeat (3) @(negedge clk_tb);
    trigger = 1'b1;
    for (int n = 1; n <= TRIG_LAT; n++) begin
      @(negedge clk_tb);
      if (n == 1) trigger = 1'b0;
      if (n == TRIG_LAT - 1) begin
        n_cmp++;
        if (mem_addr !== 16'd0 || status !== ST_RUN) begin
          n_err++;
          $display("FAIL wt_hold got a=%h st=%b want a=0 st=%b",
                   mem_addr, status, ST_RUN);
        end
      end
    end
    n_cmp++;
    if (mem_addr !== 16'd1 || status !== ST_RUN) begin
      n_err++;
      $display("FAIL wt_fetch got a=%h st=%b want a=1 st=%b",
               mem_addr, status, ST_RUN);
    end
    run = 1'b0;
    @(negedge clk_tb);
  endtask

  task automatic test_jump_abort();
    clear_prog();
    prog[0] = mk(4'd0, 64'd9, '0, '0);
    prog[1] = mk(4'd5, 64'hFF, 20'd0, 32'd10);
    run = 1'b1;
    repeat (6) @(negedge clk_tb);
    n_cmp++;
    if (channels !== 64'd9 || mem_addr !== 16'd1 ||
        status !== ST_RUN) begin
      n_err++;
      $display("FAIL ja_hold got ch=%h a=%h st=%b want 9 1 %b",
               channels, mem_addr, status, ST_RUN);
    end
    run = 1'b0;
    @(negedge clk_tb);
    n_cmp++;
    if (status !== ST_IDL || channels !== 64'd9 ||
        mem_addr !== 16'd0) begin
      n_err++;
      $display("FAIL ja_abort got st=%b ch=%h a=%h want %b 9 0",
               status, channels, mem_addr, ST_IDL);
    end
  endtask

  task automatic test_bad_op();
    clear_prog();
    prog[0] = mk(4'd0, 64'h33, '0, '0);
    prog[1] = mk(4'd9, 64'hFF, '0, '0);
    run = 1'b1;
    repeat (5) @(negedge clk_tb);
    n_cmp++;
    if (status !== ST_ERR || channels !== 64'h33 ||
        mem_addr !== 16'd1) begin
      n_err++;
      $display("FAIL bad_err got st=%b ch=%h a=%h want %b 33 1",
               status, channels, mem_addr, ST_ERR);
    end
    repeat (3) @(negedge clk_tb);
    n_cmp++;
    if (status !== ST_ERR) begin
      n_err++;
      $display("FAIL bad_stay got %b want %b", status, ST_ERR);
    end
    reset = 1'b1;
    @(negedge clk_tb);
    n_cmp++;
    if (channels !== 64'd0 || mem_addr !== 16'd0 ||
        status !== ST_IDL || loop_level !== 3'd0) begin
      n_err++;
      $display("FAIL bad_reset got ch=%h a=%h st=%b l=%0d want 0 0 %b 0",
               channels, mem_addr, status, loop_level, ST_IDL);
    end
    reset = 1'b0;
    run = 1'b0;
    @(negedge clk_tb);
  endtask

  task automatic test_random();
    exp_t q[$];
    ins_t ins;
    logic [15:0] pc, fpc;
    logic [63:0] ch;
    logic [15:0] sa [4];
    logic [19:0] sc [4];
    logic [4:0]  hst;
    int d;
    bit halt;
    for (int p = 0; p < 30; p++) begin
      for (int i = 0; i < 16; i++) prog[i] = rand_ins();
      q.delete();
      pc = '0; fpc = '0; ch = '0; d = 0; halt = 0; hst = ST_DON;
      while (q.size() < NCYC) begin
        if (halt) begin
          q.push_back(ex(ch, fpc, hst, d));
        end else begin
          ins = prog[pc[3:0]];
          fpc = pc;
          q.push_back(ex(ch, fpc, ST_RUN, d));
          q.push_back(ex(ch, fpc, ST_RUN, d));
          case (ins.op)
            4'd0: begin ch = ins.flg; pc = pc + 16'd1; end
            4'd1: begin halt = 1; hst = ST_DON; end
            4'd2: begin
              if (d == 4) begin
                halt = 1; hst = ST_ERR;
              end else begin
                sa[d] = pc + 16'd1;
                sc[d] = ins.data;
                d++;
                ch = ins.flg;
                pc = pc + 16'd1;
              end
            end
            4'd3: begin
              if (d == 0) begin
                halt = 1; hst = ST_ERR;
              end else begin
                ch = ins.flg;
                if (sc[d-1] == 0) begin
                  d--;
                  pc = pc + 16'd1;
                end else begin
                  sc[d-1] = sc[d-1] - 20'd1;
                  pc = sa[d-1];
                end
              end
            end
            4'd5: pc = ins.data[15:0];
            default: begin halt = 1; hst = ST_ERR; end
          endcase
          if (!halt)
            for (int h = 0; h < int'(ins.t); h++)
              q.push_back(ex(ch, fpc, ST_RUN, d));
        end
      end
      do_reset();
      run = 1'b1;
      for (int c = 0; c < NCYC; c++) begin
        @(negedge clk_tb);
        n_cmp++;
        if ({channels, mem_addr, status, loop_level} !== q[c]) begin
          n_err++;
          $display("FAIL rand p%0d c%0d got ch=%h a=%h st=%b l=%0d want ch=%h a=%h st=%b l=%0d",
                   p, c, channels, mem_addr, status, loop_level,
                   q[c].ch, q[c].addr, q[c].st, q[c].lvl);
        end
      end
      run = 1'b0;
      @(negedge clk_tb);
    end
  endtask

  initial begin
    reset = 1'b1;
    run = 1'b0;
    trigger = 1'b0;
    clear_prog();
    test_reset();
    test_cont_stop();
    test_loop();
    test_overflow();
    test_wait_trig();
    test_jump_abort();
    test_bad_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
